hazard_sched: RTL and testbench

//  Pipeline hazard scheduler for the 5-stage RV32I core. Sits beside the ID-stage decoder and

---
 rtl/hazard_sched_pkg.sv | 35 +++
 rtl/hazard_sched_fwd_pick.sv | 28 ++
 rtl/hazard_sched.sv | 121 ++++++++++++
 tb/tb_hazard_sched.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sched_pkg.sv
// Shared types for the hazard scheduler: decoder op types, forwarding selects,
// and the shadow pipeline-stage record tracked for EX and MEM.
package hazard_sched_pkg;

  localparam int REG_AW_P = 5;

  // Must stay identical to the decoder's hazard_optype encoding.
  typedef enum logic [1:0] {
    OPTYPE_NONE  = 2'b00,
    OPTYPE_ALU   = 2'b01,
    OPTYPE_LOAD  = 2'b10,
    OPTYPE_STORE = 2'b11
  } optype_e;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EX    = 2'b01,
    FWD_MEM   = 2'b10,
    FWD_MEMLD = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_AW_P-1:0] rd;
    logic                we;
    optype_e             typ;
  } stage_t;

  localparam stage_t STAGE_BUBBLE = '{rd: '0, we: 1'b0, typ: OPTYPE_NONE};

  // x0 is hardwired zero, so it never creates a dependence.
  function automatic logic reg_match(input logic [REG_AW_P-1:0] src, input stage_t st);
    return (src != '0) && st.we && (st.rd == src);
  endfunction

endpackage

// File: rtl/hazard_sched_fwd_pick.sv
// Forwarding select for one ID source operand: EX (non-load) outranks MEM,
// MEM loads forward their load data, otherwise read the register file.
module hazard_sched_fwd_pick
  import hazard_sched_pkg::*;
(
  input  logic [REG_AW_P-1:0] rs,
  input  logic                rs_use,
  input  stage_t              ex_stage,
  input  stage_t              mem_stage,
  output fwd_sel_e            sel,
  output logic                ex_match
);

  logic mem_match;

  assign ex_match  = reg_match(rs, ex_stage);
  assign mem_match = reg_match(rs, mem_stage);

  always_comb begin
    sel = FWD_RF;
    if (rs_use && ex_match && (ex_stage.typ != OPTYPE_LOAD)) begin
      sel = FWD_EX;
    end else if (mem_match) begin
      sel = (mem_stage.typ == OPTYPE_LOAD) ? FWD_MEMLD : FWD_MEM;
    end
  end

endmodule

// File: rtl/hazard_sched.sv
// ID-stage hazard scheduler: shadows EX/MEM destinations, derives forwarding,
// load-use stall, branch flush, late store-data forward and saturating counters.
module hazard_sched
  import hazard_sched_pkg::*;
#(
  parameter int REG_AW = REG_AW_P,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_rs1use,
  input  logic              id_rs2use,
  input  logic              id_regwrite,
  input  logic [1:0]        id_optype,
  input  logic              id_br_taken,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_bubble,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              ex_store_fwd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_t            ex_q, ex_d;
  stage_t            mem_q, mem_d;
  logic              ex_store_fwd_q, ex_store_fwd_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  optype_e           id_type;
  fwd_sel_e          fwd_a, fwd_b;
  logic              ex_match_a, ex_match_b;
  logic              store_rs2_only;
  logic              load_use;
  logic              flush;

  assign id_type = optype_e'(id_optype);

  hazard_sched_fwd_pick u_fwd_a (
    .rs        (id_rs1),
    .rs_use    (id_rs1use),
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .sel       (fwd_a),
    .ex_match  (ex_match_a)
  );

  hazard_sched_fwd_pick u_fwd_b (
    .rs        (id_rs2),
    .rs_use    (id_rs2use),
    .ex_stage  (ex_q),
    .mem_stage (mem_q),
    .sel       (fwd_b),
    .ex_match  (ex_match_b)
  );

  // A store whose only tie to the load is its data operand can proceed:
  // the data is picked up from MEM load data one cycle later in EX.
  always_comb begin
    store_rs2_only = (id_type == OPTYPE_STORE) && !(id_rs1use && ex_match_a) &&
                     (id_rs2 == ex_q.rd);
    load_use = id_valid && (ex_q.typ == OPTYPE_LOAD) &&
               ((id_rs1use && ex_match_a) ||
                (id_rs2use && ex_match_b && !store_rs2_only));
    flush    = id_br_taken && !load_use;
  end

  always_comb begin
    mem_d = ex_q;
    ex_d  = STAGE_BUBBLE;
    if (id_valid && !load_use) begin
      ex_d.rd  = id_rd;
      ex_d.we  = id_regwrite;
      ex_d.typ = id_type;
    end
    ex_store_fwd_d = id_valid && (id_type == OPTYPE_STORE) &&
                     (ex_q.typ == OPTYPE_LOAD) && ex_match_b && !load_use;
    stall_cnt_d = stall_cnt_q;
    if (load_use && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q           <= STAGE_BUBBLE;
      mem_q          <= STAGE_BUBBLE;
      ex_store_fwd_q <= 1'b0;
      stall_cnt_q    <= '0;
      flush_cnt_q    <= '0;
    end else begin
      ex_q           <= ex_d;
      mem_q          <= mem_d;
      ex_store_fwd_q <= ex_store_fwd_d;
      stall_cnt_q    <= stall_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign pc_stall     = load_use;
  assign ifid_stall   = load_use;
  assign idex_bubble  = load_use;
  assign ifid_flush   = flush;
  assign fwd_a_sel    = fwd_a;
  assign fwd_b_sel    = fwd_b;
  assign ex_store_fwd = ex_store_fwd_q;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed hazard scenarios plus a random instruction
// stream, all checked against an in-flight instruction list model.
module tb_hazard_sched;

  localparam int CW = 6;
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [1:0] T_NONE = 2'd0, T_ALU = 2'd1, T_LOAD = 2'd2, T_STORE = 2'd3;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          id_valid = 1'b0;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic          id_rs1use = 1'b0, id_rs2use = 1'b0, id_regwrite = 1'b0;
  logic [1:0]    id_optype = '0;
  logic          id_br_taken = 1'b0;
  logic          pc_stall, ifid_stall, ifid_flush, idex_bubble, ex_store_fwd;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_sched #(.REG_AW(5), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1use(id_rs1use), .id_rs2use(id_rs2use), .id_regwrite(id_regwrite),
    .id_optype(id_optype), .id_br_taken(id_br_taken), .pc_stall(pc_stall),
    .ifid_stall(ifid_stall), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .ex_store_fwd(ex_store_fwd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    logic       valid;
    logic [1:0] typ;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, rw, br;
  } instr_t;

  typedef struct {
    logic       we;
    logic [4:0] rd;
    logic [1:0] typ;
  } rec_t;

  // reference model: instructions still in flight, [0] one ahead of ID, [1] two ahead
  rec_t          inflight[2];
  logic          exp_sf;
  logic [CW-1:0] exp_stalls, exp_flushes;

  int n_cmp = 0;
  int n_bad = 0;

  logic          obs_lu, obs_fl, obs_sf;
  logic [1:0]    obs_fa, obs_fb;
  logic [CW-1:0] obs_scnt, obs_fcnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic writes(input rec_t r, input logic [4:0] s);
    return (s != 5'd0) && r.we && (r.rd == s);
  endfunction

  // Who supplies a source value: the ALU result one ahead (if it is not a load
  // and the operand is used), else whatever is two ahead, else the regfile.
  function automatic logic [1:0] m_fwd(input logic [4:0] s, input logic use_s);
    if (use_s && writes(inflight[0], s) && inflight[0].typ != T_LOAD) return 2'd1;
    if (writes(inflight[1], s)) return (inflight[1].typ == T_LOAD) ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_load_use(input instr_t ins);
    logic need1, need2;
    if (!ins.valid || inflight[0].typ != T_LOAD) return 1'b0;
    need1 = ins.u1 && writes(inflight[0], ins.rs1);
    // a store's data can be taken late, so only address dependence stalls it
    need2 = ins.u2 && writes(inflight[0], ins.rs2) && !(ins.typ == T_STORE && !need1);
    return need1 || need2;
  endfunction

  task automatic model_reset();
    inflight[0] = '{we: 1'b0, rd: 5'd0, typ: T_NONE};
    inflight[1] = '{we: 1'b0, rd: 5'd0, typ: T_NONE};
    exp_sf      = 1'b0;
    exp_stalls  = '0;
    exp_flushes = '0;
  endtask

  task automatic apply(input instr_t ins);
    id_valid    = ins.valid;
    id_optype   = ins.typ;
    id_rd       = ins.rd;
    id_rs1      = ins.rs1;
    id_rs2      = ins.rs2;
    id_rs1use   = ins.u1;
    id_rs2use   = ins.u2;
    id_regwrite = ins.rw;
    id_br_taken = ins.br;
  endtask

  // driver: called at a negedge, checks mid-cycle, advances model, returns at next negedge
  task automatic run_cycle(input instr_t ins);
    logic lu, fl;
    apply(ins);
    #2;
    lu = m_load_use(ins);
    fl = ins.br && !lu;
    check_eq("pc_stall", pc_stall, lu);
    check_eq("ifid_stall", ifid_stall, lu);
    check_eq("idex_bubble", idex_bubble, lu);
    check_eq("ifid_flush", ifid_flush, fl);
    check_eq("fwd_a_sel", fwd_a_sel, m_fwd(ins.rs1, ins.u1));
    check_eq("fwd_b_sel", fwd_b_sel, m_fwd(ins.rs2, ins.u2));
    check_eq("ex_store_fwd", ex_store_fwd, exp_sf);
    check_eq("stall_cnt", stall_cnt, exp_stalls);
    check_eq("flush_cnt", flush_cnt, exp_flushes);
    obs_lu = pc_stall; obs_fl = ifid_flush; obs_sf = ex_store_fwd;
    obs_fa = fwd_a_sel; obs_fb = fwd_b_sel;
    obs_scnt = stall_cnt; obs_fcnt = flush_cnt;
    exp_sf = ins.valid && ins.typ == T_STORE && inflight[0].typ == T_LOAD &&
             writes(inflight[0], ins.rs2) && !lu;
    if (lu && exp_stalls != CMAX) exp_stalls++;
    if (fl && exp_flushes != CMAX) exp_flushes++;
    inflight[1] = inflight[0];
    if (ins.valid && !lu) inflight[0] = '{we: ins.rw, rd: ins.rd, typ: ins.typ};
    else                  inflight[0] = '{we: 1'b0, rd: 5'd0, typ: T_NONE};
    @(negedge clk);
  endtask

  function automatic instr_t mk(input logic v, input logic [1:0] t, input logic [4:0] rd,
                                input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                                input logic u2, input logic rw, input logic br);
    instr_t i;
    i.valid = v; i.typ = t; i.rd = rd; i.rs1 = r1; i.rs2 = r2;
    i.u1 = u1; i.u2 = u2; i.rw = rw; i.br = br;
    return i;
  endfunction

  function automatic instr_t nop();
    return mk(1'b0, T_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
    return mk(1'b1, T_ALU, rd, r1, r2, 1'b1, 1'b1, 1'b1, 1'b0);
  endfunction
  function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] r1);
    return mk(1'b1, T_LOAD, rd, r1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic instr_t sw(input logic [4:0] data, input logic [4:0] base);
    return mk(1'b1, T_STORE, 5'd0, base, data, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic instr_t beq(input logic [4:0] r1, input logic [4:0] r2, input logic tk);
    return mk(1'b1, T_NONE, 5'd0, r1, r2, 1'b1, 1'b1, 1'b0, tk);
  endfunction

  function automatic instr_t rand_instr();
    instr_t i;
    i = mk($urandom_range(0, 9) != 0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0, 1'b0);
    case (i.typ)
      T_ALU:   begin i.u1 = 1'b1; i.u2 = 1'($urandom_range(0, 1)); i.rw = 1'b1; end
      T_LOAD:  begin i.u1 = 1'b1; i.rw = 1'b1; end
      T_STORE: begin i.u1 = 1'b1; i.u2 = 1'b1; end
      default: begin
        i.u1 = 1'($urandom_range(0, 1)); i.u2 = i.u1;
        i.br = i.u1 && ($urandom_range(0, 3) == 0);
      end
    endcase
    return i;
  endfunction

  initial begin
    instr_t cur;
    model_reset();
    // reset state
    repeat (2) @(negedge clk);
    #2;
    check_eq("rst pc_stall", pc_stall, 1'b0);
    check_eq("rst fwd_a", fwd_a_sel, 2'd0);
    check_eq("rst stall_cnt", stall_cnt, '0);
    check_eq("rst flush_cnt", flush_cnt, '0);
    @(negedge clk);
    rst_n = 1'b1;

    // ALU -> ALU forwarding distances, and x0 writer
    run_cycle(nop()); run_cycle(nop());
    run_cycle(alu(5'd5, 5'd1, 5'd2));
    run_cycle(alu(5'd6, 5'd5, 5'd1));
    check_eq("dist1 fwd_a", obs_fa, 2'd1);
    run_cycle(nop()); run_cycle(nop());
    run_cycle(alu(5'd5, 5'd1, 5'd2));
    run_cycle(alu(5'd7, 5'd3, 5'd4));
    run_cycle(alu(5'd6, 5'd5, 5'd1));
    check_eq("dist2 fwd_a", obs_fa, 2'd2);
    run_cycle(alu(5'd0, 5'd1, 5'd2));
    run_cycle(alu(5'd6, 5'd0, 5'd0));
    check_eq("x0 fwd_a", obs_fa, 2'd0);
    check_eq("x0 fwd_b", obs_fb, 2'd0);

    // load-use
    run_cycle(nop()); run_cycle(nop());
    run_cycle(lw(5'd5, 5'd2));
    run_cycle(alu(5'd6, 5'd5, 5'd5));
    check_eq("lu stall", obs_lu, 1'b1);
    run_cycle(alu(5'd6, 5'd5, 5'd5));
    check_eq("lu retry stall", obs_lu, 1'b0);
    check_eq("lu retry fwd_a", obs_fa, 2'd3);
    check_eq("lu retry fwd_b", obs_fb, 2'd3);
    check_eq("lu stall_cnt", obs_scnt, 6'd1);

    // load -> store data vs store address
    run_cycle(nop()); run_cycle(nop());
    run_cycle(lw(5'd5, 5'd3));
    run_cycle(sw(5'd5, 5'd2));
    check_eq("sw data no stall", obs_lu, 1'b0);
    run_cycle(nop());
    check_eq("ex_store_fwd set", obs_sf, 1'b1);
    run_cycle(nop());
    check_eq("ex_store_fwd clear", obs_sf, 1'b0);
    run_cycle(lw(5'd5, 5'd3));
    run_cycle(sw(5'd7, 5'd5));
    check_eq("sw addr stall", obs_lu, 1'b1);
    run_cycle(sw(5'd7, 5'd5));

    // load then taken branch on it: stall wins, flush next cycle
    run_cycle(nop()); run_cycle(nop());
    run_cycle(lw(5'd5, 5'd3));
    run_cycle(beq(5'd5, 5'd0, 1'b1));
    check_eq("br stall", obs_lu, 1'b1);
    check_eq("br no flush", obs_fl, 1'b0);
    run_cycle(beq(5'd5, 5'd0, 1'b1));
    check_eq("br flush", obs_fl, 1'b1);
    run_cycle(nop());
    check_eq("flush_cnt", obs_fcnt, 6'd1);

    // random stream: stalled instruction is re-presented, flush kills the next one
    cur = rand_instr();
    for (int k = 0; k < 1500; k++) begin
      run_cycle(cur);
      if (obs_lu) ;
      else if (obs_fl) cur = nop();
      else cur = rand_instr();
      if (!obs_lu && obs_fl) begin
        run_cycle(cur);
        cur = rand_instr();
      end
    end

    // asynchronous reset in the middle of a stall
    run_cycle(lw(5'd5, 5'd1));
    apply(alu(5'd6, 5'd5, 5'd5));
    #1;
    check_eq("pre-rst stall", pc_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("mid rst pc_stall", pc_stall, 1'b0);
    check_eq("mid rst idex_bubble", idex_bubble, 1'b0);
    check_eq("mid rst fwd_a", fwd_a_sel, 2'd0);
    check_eq("mid rst ex_store_fwd", ex_store_fwd, 1'b0);
    check_eq("mid rst stall_cnt", stall_cnt, '0);
    check_eq("mid rst flush_cnt", flush_cnt, '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle(alu(5'd6, 5'd5, 5'd5));
    check_eq("post rst fwd_a", obs_fa, 2'd0);

    // stall counter saturation
    while (exp_stalls != CMAX) begin
      run_cycle(lw(5'd5, 5'd1));
      run_cycle(alu(5'd6, 5'd5, 5'd5));
      run_cycle(alu(5'd6, 5'd5, 5'd5));
    end
    run_cycle(lw(5'd5, 5'd1));
    run_cycle(alu(5'd6, 5'd5, 5'd5));
    check_eq("sat stall seen", obs_lu, 1'b1);
    run_cycle(alu(5'd6, 5'd5, 5'd5));
    run_cycle(nop());
    check_eq("sat stall_cnt", obs_scnt, CMAX);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
